// File: rtl/rs_age_ordered_pkg.sv
// Shared types for the age-ordered reservation station.
// Dispatch payload, issue payload, RS entry and the ROB age helper.
package rs_age_ordered_pkg;

  localparam int PREG_W   = 7;
  localparam int ROB_W    = 5;
  localparam int OPC_W    = 8;
  localparam int RS_DEPTH = 8;
  localparam int RS_IDX_W = $clog2(RS_DEPTH);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [ROB_W-1:0]  rob_t;

  typedef struct packed {
    rob_t              rob_index;
    preg_t             pr1;
    preg_t             pr2;
    preg_t             prd;
    logic              pr1_ready;
    logic              pr2_ready;
    logic [OPC_W-1:0]  opcode;
  } dispatch_pipeline_data;

  typedef struct packed {
    rob_t              rob_index;
    preg_t             pr1;
    preg_t             pr2;
    preg_t             prd;
    logic [OPC_W-1:0]  opcode;
  } rs_data;

  typedef struct packed {
    logic              busy;
    rob_t              rob_index;
    preg_t             pr1;
    logic              pr1_ready;
    preg_t             pr2;
    logic              pr2_ready;
    preg_t             prd;
    logic [OPC_W-1:0]  payload;
  } rs_entry_t;

  // Distance from the ROB head; wraps naturally in ROB_W bits.
  function automatic rob_t rob_age(rob_t tag, rob_t head);
    return tag - head;
  endfunction

endpackage

// File: rtl/rs_age_ordered_if.sv
// Dispatch and issue handshakes of the reservation station.
// slave is the RS view, master the dispatch/FU view.
interface rs_age_ordered_if;
  import rs_age_ordered_pkg::*;

  logic                  valid_in;
  logic                  ready_in;
  dispatch_pipeline_data instr;
  logic                  fu_rdy;
  logic                  valid_out;
  rs_data                data_out;

  modport master (
    output valid_in, instr, fu_rdy,
    input  ready_in, valid_out, data_out
  );

  modport slave (
    input  valid_in, instr, fu_rdy,
    output ready_in, valid_out, data_out
  );

endinterface

// File: rtl/rs_age_ordered_pick.sv
// Combinational oldest-ready picker.
// Strict less-than keeps the lowest index on an age tie.
module rs_oldest_pick #(
  parameter  int N  = 8,
  parameter  int AW = 5,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]         i_rdy,
  input  logic [N-1:0][AW-1:0] i_age,
  output logic                 o_found,
  output logic [IW-1:0]        o_idx
);

  logic [AW-1:0] w_best;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_best  = '0;
    for (int i = 0; i < N; i++) begin
      if (i_rdy[i] && (!o_found || i_age[i] < w_best)) begin
        o_found = 1'b1;
        o_idx   = IW'(i);
        w_best  = i_age[i];
      end
    end
  end

endmodule

// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station with wakeup and wrap-safe flush.
// RS_DISPATCH_BYPASS_EN: same-cycle wakeup of dispatched sources.
module rs_age_ordered
  import rs_age_ordered_pkg::*;
#(
  parameter int DEPTH    = RS_DEPTH,
  parameter int NUM_WAKE = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  rs_age_ordered_if.slave                  bus,
  input  logic [NUM_WAKE-1:0][PREG_W-1:0]  wake_tag,
  input  logic [NUM_WAKE-1:0]              wake_valid,
  input  rob_t                             rob_head,
  input  logic                             flush,
  input  rob_t                             flush_tag
);

  localparam int IW = $clog2(DEPTH);

  rs_entry_t                    r_ent [DEPTH];
  logic                         r_valid;
  rs_data                       r_data;

  logic [DEPTH-1:0]             w_rdy;
  logic [DEPTH-1:0]             w_kill;
  logic [DEPTH-1:0]             w_wk1;
  logic [DEPTH-1:0]             w_wk2;
  logic [DEPTH-1:0][ROB_W-1:0]  w_age;
  rob_t                         w_fage;
  logic                         w_free;
  logic [IW-1:0]                w_fidx;
  logic                         w_found;
  logic [IW-1:0]                w_pick;
  logic                         w_disp;
  logic                         w_issue;
  logic                         w_d1;
  logic                         w_d2;

  // x0 is never broadcast-woken; it is ready from dispatch.
  function automatic logic woken(
    preg_t                            t,
    logic [NUM_WAKE-1:0][PREG_W-1:0]  tags,
    logic [NUM_WAKE-1:0]              vld
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKE; k++) begin
      if (vld[k] && tags[k] == t && t != '0) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    w_fage = rob_age(flush_tag, rob_head);
    w_free = 1'b0;
    w_fidx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_age[i]  = rob_age(r_ent[i].rob_index, rob_head);
      w_rdy[i]  = r_ent[i].busy && r_ent[i].pr1_ready
                  && r_ent[i].pr2_ready;
      w_kill[i] = r_ent[i].busy && flush && (w_age[i] > w_fage);
      w_wk1[i]  = woken(r_ent[i].pr1, wake_tag, wake_valid);
      w_wk2[i]  = woken(r_ent[i].pr2, wake_tag, wake_valid);
      if (!r_ent[i].busy) begin
        w_free = 1'b1;
        w_fidx = IW'(i);
      end
    end
  end

  rs_oldest_pick #(
    .N  (DEPTH),
    .AW (ROB_W)
  ) u_pick (
    .i_rdy   (w_rdy),
    .i_age   (w_age),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

`ifdef RS_DISPATCH_BYPASS_EN
  assign w_d1 = bus.instr.pr1_ready
              | woken(bus.instr.pr1, wake_tag, wake_valid);
  assign w_d2 = bus.instr.pr2_ready
              | woken(bus.instr.pr2, wake_tag, wake_valid);
`else
  assign w_d1 = bus.instr.pr1_ready;
  assign w_d2 = bus.instr.pr2_ready;
`endif

  assign bus.ready_in  = w_free && !flush;
  assign w_disp        = bus.valid_in && bus.ready_in;
  assign w_issue       = bus.fu_rdy && w_found && !flush;
  assign bus.valid_out = r_valid;
  assign bus.data_out  = r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_issue;
      if (w_issue) begin
        r_data <= '{
          rob_index: r_ent[w_pick].rob_index,
          pr1:       r_ent[w_pick].pr1,
          pr2:       r_ent[w_pick].pr2,
          prd:       r_ent[w_pick].prd,
          opcode:    r_ent[w_pick].payload
        };
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ent[i].busy) begin
          if (w_wk1[i]) r_ent[i].pr1_ready <= 1'b1;
          if (w_wk2[i]) r_ent[i].pr2_ready <= 1'b1;
          if (w_kill[i] || (w_issue && w_pick == IW'(i)))
            r_ent[i].busy <= 1'b0;
        end else if (w_disp && w_fidx == IW'(i)) begin
          r_ent[i] <= '{
            busy:      1'b1,
            rob_index: bus.instr.rob_index,
            pr1:       bus.instr.pr1,
            pr1_ready: w_d1,
            pr2:       bus.instr.pr2,
            pr2_ready: w_d2,
            prd:       bus.instr.prd,
            payload:   bus.instr.opcode
          };
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_age_ordered.sv
// Randomised and directed bench for rs_age_ordered.
// Reference is a queue of resident instructions picked by ROB age.
module tb_rs_age_ordered;
  import rs_age_ordered_pkg::*;

  localparam int D  = 8;
  localparam int NW = 3;
  localparam int RW = 1 << ROB_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_age_ordered_if bus ();
  logic [NW-1:0][PREG_W-1:0] wake_tag;
  logic [NW-1:0]             wake_valid;
  rob_t                      rob_head;
  logic                      flush;
  rob_t                      flush_tag;

  rs_age_ordered #(.DEPTH(D), .NUM_WAKE(NW)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .bus        (bus),
    .wake_tag   (wake_tag),
    .wake_valid (wake_valid),
    .rob_head   (rob_head),
    .flush      (flush),
    .flush_tag  (flush_tag)
  );

  typedef struct {
    rs_data d;
    bit     r1;
    bit     r2;
  } ment_t;

  ment_t  mq[$];
  int     iss_log[$];
  int     checks = 0;
  int     errors = 0;
  logic   exp_v = 1'b0;
  rs_data exp_d = '0;
  bit     chk_en = 1'b0;
  bit     last_acc;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int age(int t, int h);
    return ((t - h) % RW + RW) % RW;
  endfunction

  function automatic bit woke(int t);
    if (t == 0) return 1'b0;
    for (int k = 0; k < NW; k++)
      if (wake_valid[k] && int'(wake_tag[k]) == t) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("valid_out", bus.valid_out, exp_v);
      if (exp_v) chk("data_out", bus.data_out, exp_d);
      if (bus.valid_out === 1'b1)
        iss_log.push_back(int'(bus.data_out.rob_index));
    end
  end

  // One cycle: predict from the resident set, then clock.
  task automatic step();
    int best;
    bit rdy;
    ment_t e;
    #1;
    rdy = (mq.size() < D) && !flush;
    chk("ready_in", bus.ready_in, rdy);
    best = -1;
    foreach (mq[i]) begin
      if (mq[i].r1 && mq[i].r2 && (best < 0 ||
          age(mq[i].d.rob_index, rob_head) <
          age(mq[best].d.rob_index, rob_head)))
        best = i;
    end
    if (bus.fu_rdy && best >= 0 && !flush) begin
      exp_v = 1'b1;
      exp_d = mq[best].d;
      mq.delete(best);
    end else begin
      exp_v = 1'b0;
    end
    foreach (mq[i]) begin
      if (woke(mq[i].d.pr1)) mq[i].r1 = 1'b1;
      if (woke(mq[i].d.pr2)) mq[i].r2 = 1'b1;
    end
    if (flush) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if (age(mq[i].d.rob_index, rob_head) > age(flush_tag, rob_head))
          mq.delete(i);
    end
    last_acc = bus.valid_in && rdy;
    if (last_acc) begin
      e.d.rob_index = bus.instr.rob_index;
      e.d.pr1 = bus.instr.pr1;
      e.d.pr2 = bus.instr.pr2;
      e.d.prd = bus.instr.prd;
      e.d.opcode = bus.instr.opcode;
      e.r1 = bus.instr.pr1_ready;
      e.r2 = bus.instr.pr2_ready;
`ifdef RS_DISPATCH_BYPASS_EN
      e.r1 = e.r1 | woke(bus.instr.pr1);
      e.r2 = e.r2 | woke(bus.instr.pr2);
`endif
      mq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    flush = 1'b0;
    wake_valid = '0;
  endtask

  task automatic set_instr(int rob, int p1, bit r1, int p2, bit r2);
    bus.instr.rob_index = rob_t'(rob);
    bus.instr.pr1 = preg_t'(p1);
    bus.instr.pr2 = preg_t'(p2);
    bus.instr.prd = preg_t'($urandom_range(127));
    bus.instr.pr1_ready = r1;
    bus.instr.pr2_ready = r2;
    bus.instr.opcode = 8'($urandom);
  endtask

  task automatic disp(int rob, int p1, bit r1, int p2, bit r2);
    bus.valid_in = 1'b1;
    set_instr(rob, p1, r1, p2, r2);
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wake(int port, int tag);
    wake_valid[port] = 1'b1;
    wake_tag[port] = preg_t'(tag);
  endtask

  task automatic chk_log(string name, int n, int a = 0,
                         int b = 0, int c = 0);
    int e[3];
    e = '{a, b, c};
    chk({name, "_count"}, iss_log.size(), n);
    for (int i = 0; i < n && i < 3 && i < iss_log.size(); i++)
      chk(name, iss_log[i], e[i]);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    bus.valid_in = 1'b0;
    bus.fu_rdy = 1'b0;
    bus.instr = '0;
    flush = 1'b0;
    flush_tag = '0;
    wake_valid = '0;
    wake_tag = '0;
    rob_head = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_valid_out", bus.valid_out, 1'b0);
    chk("rst_data_out", bus.data_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    iss_log.delete();
    exp_v = 1'b0;
    exp_d = '0;
    chk_en = 1'b1;
  endtask

  int  next_tag;
  int  infl;
  int  oldest;
  bit  was_fl;
  int  fl_tag;

  initial begin
    // flush without wrap
    do_reset();
    bus.fu_rdy = 1'b1;
    disp(2, 10, 0, 0, 1);
    disp(5, 10, 0, 0, 1);
    disp(7, 10, 0, 0, 1);
    flush = 1'b1;
    flush_tag = 5'd5;
    step();
    #1 chk("t1_ready_after_flush", bus.ready_in, 1'b1);
    wake(0, 10);
    step();
    idle(4);
    chk_log("t1_flush", 2, 2, 5);

    // flush across wrap
    do_reset();
    rob_head = 5'd13;
    bus.fu_rdy = 1'b1;
    disp(13, 10, 0, 0, 1);
    disp(14, 10, 0, 0, 1);
    disp(1, 10, 0, 0, 1);
    flush = 1'b1;
    flush_tag = 5'd14;
    step();
    wake(1, 10);
    step();
    idle(4);
    chk_log("t2_wrap", 2, 13, 14);

    // age order around wrap
    do_reset();
    rob_head = 5'd30;
    disp(3, 0, 1, 0, 1);
    disp(31, 0, 1, 0, 1);
    disp(0, 0, 1, 0, 1);
    bus.fu_rdy = 1'b1;
    idle(4);
    chk_log("t3_age", 3, 31, 0, 3);

    // flush on the issue cycle
    do_reset();
    bus.fu_rdy = 1'b1;
    disp(8, 0, 1, 0, 1);
    flush = 1'b1;
    flush_tag = 5'd5;
    step();
    chk("t4_kill_vout", bus.valid_out, 1'b0);
    idle(2);
    chk_log("t4_kill", 0);
    disp(8, 0, 1, 0, 1);
    flush = 1'b1;
    flush_tag = 5'd9;
    step();
    chk("t4_keep_vout0", bus.valid_out, 1'b0);
    step();
    chk("t4_keep_vout1", bus.valid_out, 1'b1);
    chk_log("t4_keep", 1, 8);

    // two-step wakeup
    do_reset();
    bus.fu_rdy = 1'b1;
    disp(4, 12, 0, 20, 0);
    wake(2, 12);
    step();
    idle(3);
    chk_log("t5_first", 0);
    wake(0, 20);
    step();
    chk("t5_edge1", bus.valid_out, 1'b0);
    step();
    chk("t5_edge2", bus.valid_out, 1'b1);
    chk_log("t5_second", 1, 4);

    // full: ninth dispatch dropped
    do_reset();
    for (int i = 0; i < D; i++) disp(i, 11, 0, 0, 1);
    #1 chk("t6_full_ready", bus.ready_in, 1'b0);
    disp(8, 0, 1, 0, 1);
    bus.fu_rdy = 1'b1;
    idle(3);
    chk_log("t6_drop", 0);
    wake(2, 11);
    step();
    idle(10);
    chk_log("t6_drain", D, 0, 1, 2);
    #1 chk("t6_empty_ready", bus.ready_in, 1'b1);

    // dispatch coinciding with a wakeup
    do_reset();
    bus.fu_rdy = 1'b1;
    wake(1, 9);
    disp(3, 9, 0, 0, 1);
    idle(3);
`ifdef RS_DISPATCH_BYPASS_EN
    chk_log("t7_bypass", 1, 3);
`else
    chk_log("t7_nobypass", 0);
`endif

    // random traffic with a realistic ROB allocator
    do_reset();
    next_tag = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(3) == 0) begin
        if (mq.size() == 0) begin
          rob_head = rob_t'(next_tag);
        end else begin
          oldest = mq[0].d.rob_index;
          foreach (mq[i])
            if (age(mq[i].d.rob_index, rob_head) < age(oldest, rob_head))
              oldest = mq[i].d.rob_index;
          rob_head = rob_t'(oldest);
        end
      end
      infl = age(next_tag, rob_head);
      bus.fu_rdy = ($urandom_range(3) != 0);
      for (int k = 0; k < NW; k++) begin
        wake_valid[k] = 1'($urandom_range(1));
        wake_tag[k] = preg_t'($urandom_range(15));
      end
      if (infl > 0 && $urandom_range(15) == 0) begin
        flush = 1'b1;
        flush_tag = rob_t'((int'(rob_head) + $urandom_range(infl - 1)) % RW);
      end
      if (infl < 30 && $urandom_range(1) == 1) begin
        int p1;
        int p2;
        p1 = $urandom_range(15);
        p2 = $urandom_range(15);
        bus.valid_in = 1'b1;
        set_instr(next_tag, p1, (p1 == 0) || ($urandom_range(2) == 0),
                  p2, (p2 == 0) || ($urandom_range(2) == 0));
      end
      was_fl = flush;
      fl_tag = flush_tag;
      step();
      if (last_acc) next_tag = (next_tag + 1) % RW;
      if (was_fl) next_tag = (fl_tag + 1) % RW;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
